// File: rtl/mc_controller.sv
// mc_controller: main control FSM of the RV32I multi-cycle core.
// Drives all datapath enables/selects from the latched instruction fields
// and ALU flags, and owns the memory handshake (mem_ready stall + timeout).
//
// Ports:
//   clk, reset (async, active-low)
//   op, funct3, funct7b5     : latched instruction fields
//   Zero, branch_lesser      : ALU flags for branch resolution
//   mem_ready                : memory access completes this cycle
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
//   ImmSrc, AluSrcA, AluSrcB, ALUControl, ResultSrc : datapath controls
//   instr_retired            : pulse on the last state of each instruction
//   halted                   : high while in HALT
//
// Parameters: MAX_WAIT (0 = no timeout), CNT_W (wait counter width).
// Optional macro ILLEGAL_TRAP_EN: unknown ops and unsupported branch
// funct3 values halt the core instead of retiring as NOP / not-taken.
module mc_controller #(
   parameter int MAX_WAIT = 0,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       branch_lesser,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [1:0] AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ResultSrc,
   output logic       instr_retired,
   output logic       halted
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_HALT     = 4'd11;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Timeout fires on the cycle the wait count would reach MAX_WAIT.
   localparam logic [CNT_W-1:0] WAIT_LAST =
      CNT_W'(MAX_WAIT == 0 ? 0 : MAX_WAIT - 1);

   logic [3:0]       state, nxt;
   logic [CNT_W-1:0] cnt;
   logic             waiting;
   logic             timeout;
   logic             taken;

   logic       pcw, adr, irw, mw, rw, ret, hlt;
   logic [1:0] imm, sa, sb, rs;
   logic [2:0] alu;

   function automatic logic [2:0] alu_dec(input logic [2:0] f3,
                                          input logic       f7,
                                          input logic       is_r);
      logic [2:0] a;
      a = ALU_ADD;
      case (f3)
         3'b000:  a = (is_r && f7) ? ALU_SUB : ALU_ADD;
         3'b100:  a = ALU_XOR;
         3'b110:  a = ALU_OR;
         3'b111:  a = ALU_AND;
         3'b010:  a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   assign waiting = ((state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE)) && !mem_ready;
   assign timeout = (MAX_WAIT != 0) && !mem_ready && (cnt == WAIT_LAST);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = !Zero;
         3'b100:  taken = branch_lesser;
         3'b101:  taken = !branch_lesser;
         default: taken = 1'b0;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   logic br_legal;
   assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
`endif

   always_comb begin
      nxt = state;
      pcw = 1'b0;
      adr = 1'b0;
      irw = 1'b0;
      mw  = 1'b0;
      rw  = 1'b0;
      ret = 1'b0;
      hlt = 1'b0;
      imm = 2'b00;
      sa  = 2'b00;
      sb  = 2'b00;
      rs  = 2'b00;
      alu = ALU_ADD;
      unique case (state)
         S_FETCH: begin
            sb = 2'b10;
            rs = 2'b10;
            if (mem_ready) begin
               irw = 1'b1;
               pcw = 1'b1;
               nxt = S_DECODE;
            end else if (timeout) begin
               nxt = S_HALT;
            end
         end
         S_DECODE: begin
            sa  = 2'b01;
            sb  = 2'b01;
            imm = (op == OP_JAL) ? 2'b11 : 2'b10;
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_R:              nxt = S_EXECR;
               OP_I:              nxt = S_EXECI;
               OP_BR:             nxt = S_BRANCH;
               OP_JAL:            nxt = S_JAL;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  nxt = S_HALT;
`else
                  nxt = S_FETCH;
                  ret = 1'b1;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            sa  = 2'b10;
            sb  = 2'b01;
            imm = (op == OP_STORE) ? 2'b01 : 2'b00;
            nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr = 1'b1;
            if (mem_ready) nxt = S_MEMWB;
            else if (timeout) nxt = S_HALT;
         end
         S_MEMWB: begin
            rs  = 2'b01;
            rw  = 1'b1;
            ret = 1'b1;
            nxt = S_FETCH;
         end
         S_MEMWRITE: begin
            adr = 1'b1;
            mw  = 1'b1;
            if (mem_ready) begin
               ret = 1'b1;
               nxt = S_FETCH;
            end else if (timeout) begin
               nxt = S_HALT;
            end
         end
         S_EXECR: begin
            sa  = 2'b10;
            alu = alu_dec(funct3, funct7b5, 1'b1);
            nxt = S_ALUWB;
         end
         S_EXECI: begin
            sa  = 2'b10;
            sb  = 2'b01;
            alu = alu_dec(funct3, funct7b5, 1'b0);
            nxt = S_ALUWB;
         end
         S_ALUWB: begin
            rw  = 1'b1;
            ret = 1'b1;
            nxt = S_FETCH;
         end
         S_BRANCH: begin
            sa  = 2'b10;
            alu = ALU_SUB;
            nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            if (!br_legal) begin
               nxt = S_HALT;
            end else begin
               pcw = taken;
               ret = 1'b1;
            end
`else
            pcw = taken;
            ret = 1'b1;
`endif
         end
         S_JAL: begin
            sa  = 2'b01;
            sb  = 2'b10;
            pcw = 1'b1;
            nxt = S_ALUWB;
         end
         S_HALT: begin
            hlt = 1'b1;
         end
         default: nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         cnt   <= '0;
      end else begin
         state <= nxt;
         // Non-wait states always leave the counter at zero, so every
         // entry into a wait state starts from a cleared count.
         cnt   <= waiting ? cnt + 1'b1 : '0;
      end
   end

   // Gate every output with reset so nothing glitches while it is low.
   assign PCWrite       = reset & pcw;
   assign AdrSrc        = reset & adr;
   assign IRWrite       = reset & irw;
   assign MemWrite      = reset & mw;
   assign RegWrite      = reset & rw;
   assign instr_retired = reset & ret;
   assign halted        = reset & hlt;
   assign ImmSrc        = reset ? imm : 2'b00;
   assign AluSrcA       = reset ? sa  : 2'b00;
   assign AluSrcB       = reset ? sb  : 2'b00;
   assign ALUControl    = reset ? alu : ALU_ADD;
   assign ResultSrc     = reset ? rs  : 2'b00;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller (MAX_WAIT=4).
// Builds per-instruction expected cycle traces from the instruction rules.
module tb_mc_controller;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, branch_lesser, mem_ready;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
   logic [1:0] ImmSrc, AluSrcA, AluSrcB, ResultSrc;
   logic [2:0] ALUControl;
   logic       instr_retired, halted;
   logic [17:0] obs;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   typedef struct {
      logic        r;
      logic [17:0] v;
      string       tag;
   } step_t;

   step_t q[$];

   always #5 clk = ~clk;

   mc_controller #(.MAX_WAIT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .Zero(Zero), .branch_lesser(branch_lesser),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .ImmSrc(ImmSrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
      .ALUControl(ALUControl), .ResultSrc(ResultSrc),
      .instr_retired(instr_retired), .halted(halted)
   );

   assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ImmSrc,
                 AluSrcA, AluSrcB, ALUControl, ResultSrc,
                 instr_retired, halted};

   function automatic logic [17:0] ov(
      input logic pcw, adr, irw, mw, rw,
      input logic [1:0] imm, sa, sb,
      input logic [2:0] alu,
      input logic [1:0] rs,
      input logic ret, h);
      return {pcw, adr, irw, mw, rw, imm, sa, sb, alu, rs, ret, h};
   endfunction

   function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                         input logic f7, input logic is_r);
      case (f3)
         3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
         3'd4:    return 3'd4;
         3'd6:    return 3'd3;
         3'd7:    return 3'd2;
         3'd2:    return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic taken_of(input logic [2:0] f3,
                                     input logic z, input logic lt);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return lt;
         3'd5:    return !lt;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input logic r, input logic [17:0] v, input string t);
      step_t s;
      s.r = r;
      s.v = v;
      s.tag = t;
      q.push_back(s);
   endtask

   task automatic check(input string tag, input logic [17:0] o,
                        input logic [17:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Each step starts just after a rising edge.
   task automatic run_n(input int n);
      for (int i = 0; i < n && q.size() > 0; i++) begin
         step_t s;
         s = q.pop_front();
         mem_ready = s.r;
         @(negedge clk);
         check(s.tag, obs, s.v);
         @(posedge clk);
         #1;
      end
      q.delete();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("reset", obs, 18'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic model_fetch(input int fw);
      for (int i = 0; i < fw; i++)
         push(1'b0, ov(0,0,0,0,0,2'd0,2'd0,2'd2,3'd0,2'd2,0,0), "fetch_wait");
      push(1'b1, ov(1,0,1,0,0,2'd0,2'd0,2'd2,3'd0,2'd2,0,0), "fetch");
   endtask

   // Full expected trace for one instruction, memory waits included.
   task automatic model_instr(input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, z, lt,
                              input int fw, mw);
      logic known;
      logic [1:0] imm_d;
      op = o;
      funct3 = f3;
      funct7b5 = f7;
      Zero = z;
      branch_lesser = lt;
      known = (o == OP_LOAD) || (o == OP_STORE) || (o == OP_R) ||
              (o == OP_I) || (o == OP_BR) || (o == OP_JAL);
      imm_d = (o == OP_JAL) ? 2'd3 : 2'd2;
      model_fetch(fw);
      push(rnd(), ov(0,0,0,0,0,imm_d,2'd1,2'd1,3'd0,2'd0,!known,0),
           "decode");
      if (o == OP_LOAD) begin
         push(rnd(), ov(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,2'd0,0,0), "memadr_l");
         for (int i = 0; i < mw; i++)
            push(1'b0, ov(0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0),
                 "memread_wait");
         push(1'b1, ov(0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0), "memread");
         push(rnd(), ov(0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd1,1,0), "memwb");
      end else if (o == OP_STORE) begin
         push(rnd(), ov(0,0,0,0,0,2'd1,2'd2,2'd1,3'd0,2'd0,0,0), "memadr_s");
         for (int i = 0; i < mw; i++)
            push(1'b0, ov(0,1,0,1,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0),
                 "memwrite_wait");
         push(1'b1, ov(0,1,0,1,0,2'd0,2'd0,2'd0,3'd0,2'd0,1,0), "memwrite");
      end else if (o == OP_R || o == OP_I) begin
         if (o == OP_R)
            push(rnd(), ov(0,0,0,0,0,2'd0,2'd2,2'd0,alu_of(f3, f7, 1'b1),
                           2'd0,0,0), "execr");
         else
            push(rnd(), ov(0,0,0,0,0,2'd0,2'd2,2'd1,alu_of(f3, f7, 1'b0),
                           2'd0,0,0), "execi");
         push(rnd(), ov(0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd0,1,0), "aluwb");
      end else if (o == OP_BR) begin
         push(rnd(), ov(taken_of(f3, z, lt),0,0,0,0,2'd0,2'd2,2'd0,3'd1,
                        2'd0,1,0), "branch");
      end else if (o == OP_JAL) begin
         push(rnd(), ov(1,0,0,0,0,2'd0,2'd1,2'd2,3'd0,2'd0,0,0), "jal");
         push(rnd(), ov(0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd0,1,0), "jal_wb");
      end
   endtask

   task automatic model_halt(input int n);
      for (int i = 0; i < n; i++)
         push(rnd(), ov(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,1), "halt");
   endtask

   initial begin
      logic [6:0] unk [4];
      logic [6:0] kops [6];
      int k;
      unk[0] = 7'b0110111;
      unk[1] = 7'b0010111;
      unk[2] = 7'b1100111;
      unk[3] = 7'b0000000;
      kops[0] = OP_LOAD;
      kops[1] = OP_STORE;
      kops[2] = OP_R;
      kops[3] = OP_I;
      kops[4] = OP_BR;
      kops[5] = OP_JAL;
      reset = 1'b0;
      op = 7'd0;
      funct3 = 3'd0;
      funct7b5 = 1'b0;
      Zero = 1'b0;
      branch_lesser = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset(3);

      model_instr(OP_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
      run_n(100);
      model_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2);
      run_n(100);
      model_instr(OP_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
      run_n(100);
      model_instr(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, 1, 0);
      run_n(100);
      model_instr(OP_BR, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
      run_n(100);
      model_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_n(100);
      model_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 3, 3);
      run_n(100);
      model_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      run_n(100);
      model_instr(unk[0], 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_n(100);

      for (int n = 0; n < 60; n++) begin
         k = int'($urandom_range(0, 6));
         model_instr((k == 6) ? unk[$urandom_range(0, 3)] : kops[k],
                     3'($urandom_range(0, 7)), rnd(), rnd(), rnd(),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         run_n(100);
      end

      // Reset while a store is driving MemWrite.
      model_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      run_n(4);
      do_reset(2);
      model_instr(OP_I, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0);
      run_n(100);

      // Store timeout: four MemWrite cycles, then HALT.
      op = OP_STORE;
      funct3 = 3'd2;
      model_fetch(0);
      push(rnd(), ov(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd0,0,0), "decode_s");
      push(rnd(), ov(0,0,0,0,0,2'd1,2'd2,2'd1,3'd0,2'd0,0,0), "memadr_s");
      for (int i = 0; i < 4; i++)
         push(1'b0, ov(0,1,0,1,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0), "sw_timeout");
      model_halt(5);
      run_n(100);
      do_reset(2);
      model_instr(OP_R, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0);
      run_n(100);

      // Fetch timeout.
      for (int i = 0; i < 4; i++)
         push(1'b0, ov(0,0,0,0,0,2'd0,2'd0,2'd2,3'd0,2'd2,0,0), "fetch_to");
      model_halt(3);
      run_n(100);
      do_reset(1);
      model_instr(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);
      run_n(100);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
